// File: rtl/ppl_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// FSM state encoding and starvation-counter width helper.
package ppl_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_GRANT,
      ST_ACK
   } arb_state_t;

   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/ppl_starve_cnt.sv
// Saturating wait counter for pending debug requests.
// Flags when the wait has reached the starvation limit.
module ppl_starve_cnt
   import ppl_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_at_limit
);

   localparam int W = cnt_width(LIMIT);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/ppl_dmem_arb.sv
// Data-memory port arbiter: CPU memory stage has priority,
// debug port waits for a free cycle or is forced in after a bound.
module ppl_dmem_arb
   import ppl_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t r_state;
   arb_state_t w_next;

   logic              w_cpu_req;
   logic              w_grant;
   logic              w_cnt_inc;
   logic              w_cnt_clr;
   logic              w_at_limit;
   logic [DATA_W-1:0] r_dbg_rdata;

   assign w_cpu_req = cpu_rd | cpu_wr;
   assign w_grant   = (r_state == ST_GRANT);
   assign w_cnt_clr = (w_next == ST_IDLE);

   ppl_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (w_cnt_clr),
      .i_inc      (w_cnt_inc),
      .o_at_limit (w_at_limit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_inc = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (dbg_req && w_cpu_req) begin
               w_next    = ST_WAIT;
               w_cnt_inc = 1'b1;
            end else if (dbg_req) begin
               w_next = ST_GRANT;
            end
         end
         ST_WAIT: begin
            if (!dbg_req) begin
               w_next = ST_IDLE;
            end else if (!w_cpu_req || w_at_limit) begin
               w_next = ST_GRANT;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         ST_GRANT: w_next = ST_ACK;
         ST_ACK:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Reset gates every side effect so a reset in GRANT is a no-op.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_wr & ~reset;
      cpu_stall = 1'b0;
      dbg_ack   = (r_state == ST_ACK) & ~reset;
      if (w_grant) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_we    = dbg_we & ~reset;
         cpu_stall = w_cpu_req & ~reset;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dbg_rdata <= '0;
      end else if (w_grant && !dbg_we) begin
         r_dbg_rdata <= mem_rdata;
      end
   end

   assign cpu_rdata = mem_rdata;
   assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_ppl_dmem_arb.sv
// Bench for ppl_dmem_arb with a small behavioural memory.
// Scenario tasks check timing and data against a queue of expectations.
module tb_ppl_dmem_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_rd, cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          dbg_req, dbg_we, dbg_ack;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [31:0] mem [0:63];
   logic        pre_we = 1'b0;
   logic [31:0] pre_addr = '0;
   logic [31:0] pre_data = '0;

   int total = 0;
   int bad   = 0;
   logic [31:0] q_exp[$];

   ppl_dmem_arb #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial forever #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else if (pre_we) mem[pre_addr[7:2]] <= pre_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      cpu_rd = 0; cpu_wr = 0;
      cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0;
      dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      idle_in();
      reset = 1; cpu_wr = 1;
      cpu_addr = 32'h80; cpu_wdata = 32'hFFFF_FFFF;
      tick(); tick(); #1;
      total++;
      if (mem_we !== 1'b0) begin
         bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we);
      end
      total++;
      if (cpu_stall !== 1'b0) begin
         bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall);
      end
      total++;
      if (dbg_ack !== 1'b0) begin
         bad++; $display("FAIL rst_ack: got %b want 0", dbg_ack);
      end
      total++;
      if (dbg_rdata !== 32'h0) begin
         bad++; $display("FAIL rst_rdata: got %h want 0", dbg_rdata);
      end
      tick();
      reset = 0; #1;
      total++;
      if (mem_we !== 1'b1) begin
         bad++; $display("FAIL post_rst_we: got %b want 1", mem_we);
      end
      tick();
      idle_in();
   endtask

   task automatic test_cpu_passthru();
      logic [31:0] a, d, e;
      for (int i = 0; i < 8; i++) begin
         a = 32'h80 + 32'(i * 4);
         d = $urandom;
         idle_in();
         cpu_wr = 1; cpu_addr = a; cpu_wdata = d;
         #1;
         total++;
         if ({mem_we, cpu_stall, mem_addr, mem_wdata} !== {1'b1, 1'b0, a, d}) begin
            bad++;
            $display("FAIL cpu_wr_pass: got we=%b st=%b a=%h d=%h want 1 0 %h %h",
                     mem_we, cpu_stall, mem_addr, mem_wdata, a, d);
         end
         tick();
         idle_in();
         cpu_rd = 1; cpu_addr = a;
         q_exp.push_back(d);
         #1;
         e = q_exp.pop_front();
         total++;
         if (cpu_rdata !== e || cpu_stall !== 1'b0) begin
            bad++;
            $display("FAIL cpu_rd_pass: got %h st=%b want %h st=0",
                     cpu_rdata, cpu_stall, e);
         end
         tick();
      end
      idle_in();
   endtask

   task automatic test_dbg_write();
      int stall_n = 0, we_c = -1, ack_c = -1;
      logic [31:0] wa = '0, wd = '0;
      idle_in();
      dbg_req = 1; dbg_we = 1;
      dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (cpu_stall) stall_n++;
         if (mem_we && we_c < 0) begin
            we_c = c; wa = mem_addr; wd = mem_wdata;
         end
         if (dbg_ack && ack_c < 0) begin
            ack_c = c; dbg_req = 0;
         end
         tick();
      end
      total++;
      if (we_c != 1 || wa !== 32'h10 || wd !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL dw_write: got c=%0d a=%h d=%h want c=1 a=10 d=deadbeef",
                  we_c, wa, wd);
      end
      total++;
      if (ack_c != 2) begin
         bad++; $display("FAIL dw_ack_cycle: got %0d want 2", ack_c);
      end
      total++;
      if (stall_n != 0) begin
         bad++; $display("FAIL dw_stall: got %0d want 0", stall_n);
      end
      total++;
      if (mem[4] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL dw_mem: got %h want deadbeef", mem[4]);
      end
      idle_in();
   endtask

   task automatic test_dbg_read();
      int ack_c = -1;
      logic [31:0] e, hold = '0;
      idle_in();
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
      q_exp.push_back(32'hDEAD_BEEF);
      for (int c = 0; c < 8; c++) begin
         #1;
         if (dbg_ack && ack_c < 0 && q_exp.size() > 0) begin
            ack_c = c; dbg_req = 0;
            e = q_exp.pop_front(); hold = e;
            total++;
            if (dbg_rdata !== e) begin
               bad++; $display("FAIL dr_data: got %h want %h", dbg_rdata, e);
            end
         end else if (ack_c >= 0 && c <= ack_c + 3) begin
            total++;
            if (dbg_rdata !== hold || dbg_ack !== 1'b0) begin
               bad++;
               $display("FAIL dr_hold: got %h ack=%b want %h ack=0",
                        dbg_rdata, dbg_ack, hold);
            end
         end
         tick();
      end
      total++;
      if (ack_c != 2) begin
         bad++; $display("FAIL dr_ack_cycle: got %0d want 2", ack_c);
      end
      idle_in();
   endtask

   task automatic test_starve();
      int g_c = -1, st_c = -1, st_n = 0, ack_c = -1;
      logic [31:0] e;
      poke(32'h40, 32'h1234_5678);
      poke(32'h30, 32'hCAFE_0001);
      idle_in();
      cpu_rd = 1; cpu_addr = 32'h40;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h30;
      q_exp.push_back(32'hCAFE_0001);
      for (int c = 0; c < SL + 8; c++) begin
         #1;
         if (cpu_stall) begin
            st_n++;
            if (st_c < 0) st_c = c;
         end
         if (mem_addr == 32'h30 && g_c < 0) g_c = c;
         else if (g_c >= 0 && c == g_c + 1) begin
            total++;
            if (cpu_rdata !== 32'h1234_5678 || cpu_stall !== 1'b0) begin
               bad++;
               $display("FAIL sv_cpu_retry: got %h st=%b want 12345678 st=0",
                        cpu_rdata, cpu_stall);
            end
         end
         if (dbg_ack && ack_c < 0 && q_exp.size() > 0) begin
            ack_c = c; dbg_req = 0;
            e = q_exp.pop_front();
            total++;
            if (dbg_rdata !== e) begin
               bad++; $display("FAIL sv_data: got %h want %h", dbg_rdata, e);
            end
         end
         tick();
      end
      total++;
      if (g_c != SL + 1 || st_c != SL + 1 || st_n != 1) begin
         bad++;
         $display("FAIL sv_grant: got g=%0d s=%0d n=%0d want g=%0d s=%0d n=1",
                  g_c, st_c, st_n, SL + 1, SL + 1);
      end
      total++;
      if (ack_c != SL + 2) begin
         bad++; $display("FAIL sv_ack_cycle: got %0d want %0d", ack_c, SL + 2);
      end
      idle_in();
   endtask

   task automatic test_wait_release();
      int g_c = -1, s_c = -1, st_n = 0, ack_c = -1;
      idle_in();
      dbg_req = 1; dbg_we = 1;
      dbg_addr = 32'h54; dbg_wdata = 32'h0BAD_F00D;
      for (int c = 0; c < 10; c++) begin
         cpu_rd = (c < 2); cpu_wr = (c == 2);
         cpu_addr = (c == 2) ? 32'h50 : 32'h40;
         cpu_wdata = 32'hA5A5_0002;
         #1;
         if (cpu_stall) st_n++;
         if (mem_we && mem_addr == 32'h50 && s_c < 0) s_c = c;
         if (mem_we && mem_addr == 32'h54 && g_c < 0) g_c = c;
         if (dbg_ack && ack_c < 0) begin
            ack_c = c; dbg_req = 0;
         end
         tick();
      end
      total++;
      if (s_c != 2 || mem[20] !== 32'hA5A5_0002) begin
         bad++;
         $display("FAIL wr_cpu_store: got c=%0d m=%h want c=2 m=a5a50002",
                  s_c, mem[20]);
      end
      total++;
      if (g_c != 4 || st_n != 0 || ack_c != 5) begin
         bad++;
         $display("FAIL wr_grant: got g=%0d st=%0d ack=%0d want 4 0 5",
                  g_c, st_n, ack_c);
      end
      total++;
      if (mem[21] !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL wr_dbg_mem: got %h want 0badf00d", mem[21]);
      end
      idle_in();
   endtask

   task automatic test_abort();
      int ack_n = 0, we_n = 0, st_n = 0;
      poke(32'h60, 32'h1111_1111);
      idle_in();
      dbg_we = 1; dbg_addr = 32'h60; dbg_wdata = 32'h7777_7777;
      for (int c = 0; c < 10; c++) begin
         cpu_rd = (c < 4); cpu_addr = 32'h40;
         dbg_req = (c < 3);
         #1;
         if (dbg_ack) ack_n++;
         if (mem_we) we_n++;
         if (cpu_stall) st_n++;
         tick();
      end
      total++;
      if (ack_n != 0 || we_n != 0 || st_n != 0) begin
         bad++;
         $display("FAIL ab_activity: got ack=%0d we=%0d st=%0d want 0 0 0",
                  ack_n, we_n, st_n);
      end
      total++;
      if (mem[24] !== 32'h1111_1111) begin
         bad++; $display("FAIL ab_mem: got %h want 11111111", mem[24]);
      end
      idle_in();
   endtask

   task automatic test_back_to_back();
      int acks[2] = '{-1, -1};
      int n_ack = 0, st_n = 0, dbl = 0;
      logic prev = 1'b0;
      logic [31:0] e;
      idle_in();
      cpu_rd = 1; cpu_addr = 32'h40;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
      q_exp.push_back(32'hDEAD_BEEF);
      for (int c = 0; c < 24; c++) begin
         if (n_ack == 1 && c == acks[0] + 1) begin
            dbg_req = 1; dbg_addr = 32'h30;
            q_exp.push_back(32'hCAFE_0001);
         end
         #1;
         if (cpu_stall) st_n++;
         if (cpu_stall && prev) dbl++;
         prev = cpu_stall;
         if (dbg_ack && n_ack < 2 && q_exp.size() > 0) begin
            acks[n_ack] = c; n_ack++; dbg_req = 0;
            e = q_exp.pop_front();
            total++;
            if (dbg_rdata !== e) begin
               bad++; $display("FAIL bb_data: got %h want %h", dbg_rdata, e);
            end
         end
         tick();
      end
      total++;
      if (acks[0] != SL + 2 || acks[1] != 2 * SL + 5) begin
         bad++;
         $display("FAIL bb_ack_cycles: got %0d,%0d want %0d,%0d",
                  acks[0], acks[1], SL + 2, 2 * SL + 5);
      end
      total++;
      if (st_n != 2 || dbl != 0) begin
         bad++;
         $display("FAIL bb_stall: got n=%0d dbl=%0d want n=2 dbl=0", st_n, dbl);
      end
      idle_in();
   endtask

   task automatic test_reset_grant();
      poke(32'h20, 32'h2222_2222);
      idle_in();
      dbg_req = 1; dbg_we = 1;
      dbg_addr = 32'h20; dbg_wdata = 32'h9999_9999;
      tick();
      reset = 1; cpu_rd = 1; cpu_addr = 32'h40;
      #1;
      total++;
      if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL rg_in_reset: got we=%b st=%b want 0 0", mem_we, cpu_stall);
      end
      tick();
      reset = 0; dbg_req = 0;
      #1;
      total++;
      if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
         bad++;
         $display("FAIL rg_after: got ack=%b rd=%h want 0 0", dbg_ack, dbg_rdata);
      end
      total++;
      if (mem_addr !== 32'h40 || cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL rg_port: got a=%h st=%b want 40 0", mem_addr, cpu_stall);
      end
      tick();
      #1;
      total++;
      if (dbg_ack !== 1'b0 || mem[8] !== 32'h2222_2222) begin
         bad++;
         $display("FAIL rg_mem: got ack=%b m=%h want 0 22222222", dbg_ack, mem[8]);
      end
      idle_in();
   endtask

   initial begin
      idle_in();
      reset = 1;
      test_reset();
      test_cpu_passthru();
      test_dbg_write();
      test_dbg_read();
      test_starve();
      test_wait_release();
      test_abort();
      test_back_to_back();
      test_reset_grant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
